// File: rtl/i2c_cmd_sched.sv
// i2c_cmd_sched
// Shares one I2C engine between a write requester (keypad data going to the
// EEPROM) and a read requester (display refresh). Each requester has one
// pending slot. Ties are arbitrated round-robin. The block drives the
// engine's command strobes, follows eng_busy to completion, returns read
// data, and reports start/finish timeouts.
//
// Handshake summary:
//   wr_req / rd_req    one-cycle pulses. They always succeed: each sets its
//                      pending flag, and a newer write replaces an older
//                      pending write (wr_data is captured with wr_req).
//   cmd_wr / cmd_rd    strobe held high for CMD_PULSE cycles. eng_data is
//                      stable from the strobe until the op completes.
//   eng_busy           must rise within START_WIN cycles after the strobe
//                      ends, then fall within TIMEOUT cycles. The falling
//                      edge marks completion, and eng_rdata is taken then.
//   wr_done / rd_done / err   one-cycle result pulses. rd_data and err_op
//                      hold their values between pulses.
// All outputs are registered. state_dbg exposes the FSM state.
module i2c_cmd_sched #(
    parameter int CMD_PULSE = 4,
    parameter int START_WIN = 64,
    parameter int TIMEOUT   = 50000
) (
    input  logic       clkh,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    input  logic       rd_req,
    output logic       cmd_wr,
    output logic       cmd_rd,
    output logic [7:0] eng_data,
    input  logic       eng_busy,
    input  logic [7:0] eng_rdata,
    output logic       wr_done,
    output logic       rd_done,
    output logic [7:0] rd_data,
    output logic       err,
    output logic       err_op,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        DONE       = 3'd4,
        FAIL       = 3'd5
    } state_t;

    // A phase expires when the counter equals its limit minus one.
    localparam logic [19:0] PULSE_LAST   = 20'(CMD_PULSE - 1);
    localparam logic [19:0] START_LAST   = 20'(START_WIN - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [19:0] cnt, cnt_n;
    logic        wr_pend, wr_pend_n;
    logic        rd_pend, rd_pend_n;
    logic [7:0]  wr_buf, wr_buf_n;
    logic        last_wr, last_wr_n;   // 1: the last grant went to the write side
    logic        op_wr, op_wr_n;       // op of the transaction in flight (1 = write)
    logic        grant_wr, grant_rd;

    logic        cmd_wr_n, cmd_rd_n;
    logic [7:0]  eng_data_n;
    logic        wr_done_n, rd_done_n;
    logic [7:0]  rd_data_n;
    logic        err_n, err_op_n;
    logic        busy_n;

    assign state_dbg = state;

    // Registered state and outputs. Reset aborts any transaction in progress.
    always_ff @(posedge clkh) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            wr_buf   <= '0;
            last_wr  <= 1'b0;
            op_wr    <= 1'b0;
            cmd_wr   <= 1'b0;
            cmd_rd   <= 1'b0;
            eng_data <= '0;
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
            err_op   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wr_pend  <= wr_pend_n;
            rd_pend  <= rd_pend_n;
            wr_buf   <= wr_buf_n;
            last_wr  <= last_wr_n;
            op_wr    <= op_wr_n;
            cmd_wr   <= cmd_wr_n;
            cmd_rd   <= cmd_rd_n;
            eng_data <= eng_data_n;
            wr_done  <= wr_done_n;
            rd_done  <= rd_done_n;
            rd_data  <= rd_data_n;
            err      <= err_n;
            err_op   <= err_op_n;
            busy     <= busy_n;
        end
    end

    // Next state, arbitration, pending flags and next output values.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 20'd1;
        wr_pend_n  = wr_pend;
        rd_pend_n  = rd_pend;
        wr_buf_n   = wr_buf;
        last_wr_n  = last_wr;
        op_wr_n    = op_wr;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        cmd_wr_n   = 1'b0;
        cmd_rd_n   = 1'b0;
        eng_data_n = eng_data;
        wr_done_n  = 1'b0;
        rd_done_n  = 1'b0;
        rd_data_n  = rd_data;
        err_n      = 1'b0;
        err_op_n   = err_op;

        case (state)
            IDLE: begin
                cnt_n = '0;
                // On a tie, the side that was not served last wins.
                if (wr_pend && (!rd_pend || !last_wr)) begin
                    grant_wr = 1'b1;
                end else if (rd_pend) begin
                    grant_rd = 1'b1;
                end
                if (grant_wr || grant_rd) begin
                    state_n   = ISSUE;
                    op_wr_n   = grant_wr;
                    last_wr_n = grant_wr;
                    cmd_wr_n  = grant_wr;
                    cmd_rd_n  = grant_rd;
                    if (grant_wr) begin
                        eng_data_n = wr_buf;
                    end
                end
            end
            ISSUE: begin
                if (cnt == PULSE_LAST) begin
                    state_n = WAIT_START;
                    cnt_n   = '0;
                end else begin
                    cmd_wr_n = op_wr;
                    cmd_rd_n = !op_wr;
                end
            end
            WAIT_START: begin
                if (eng_busy) begin
                    state_n = WAIT_DONE;
                    cnt_n   = '0;
                end else if (cnt == START_LAST) begin
                    state_n  = FAIL;
                    cnt_n    = '0;
                    err_n    = 1'b1;
                    err_op_n = op_wr;
                end
            end
            WAIT_DONE: begin
                if (!eng_busy) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    if (op_wr) begin
                        wr_done_n = 1'b1;
                    end else begin
                        rd_done_n = 1'b1;
                        rd_data_n = eng_rdata;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n  = FAIL;
                    cnt_n    = '0;
                    err_n    = 1'b1;
                    err_op_n = op_wr;
                end
            end
            DONE, FAIL: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // A request on the same edge as its grant re-arms the flag.
        if (grant_wr) begin
            wr_pend_n = 1'b0;
        end
        if (grant_rd) begin
            rd_pend_n = 1'b0;
        end
        if (wr_req) begin
            wr_pend_n = 1'b1;
            wr_buf_n  = wr_data;
        end
        if (rd_req) begin
            rd_pend_n = 1'b1;
        end

        busy_n = (state_n != IDLE) || wr_pend_n || rd_pend_n;
    end

endmodule
